// File: rtl/vga_scandouble_pkg.sv
// Shared constants and types for the VGA scan doubler pixel path.
package vga_scandouble_pkg;

   localparam int unsigned PIX_W      = 6;
   localparam int unsigned LINE_PIX   = 448;
   localparam int unsigned VGA_PERIOD = 896;
   // hsync_start to first replayed pixel; the hsync generator preloads this value
   localparam int unsigned RD_LATENCY = 2;

   typedef struct packed {
      logic valid;
      logic half;
   } rd_meta_t;

   function automatic int unsigned cnt_width(input int unsigned n);
      return $clog2(n + 1);
   endfunction

endpackage

// File: rtl/vga_linebuf_ram.sv
// Simple dual-port line buffer: one write port, one registered read port.
module vga_linebuf_ram #(
   parameter int unsigned DATA_W = 6,
   parameter int unsigned ADDR_W = 10
) (
   input  logic              clk,
   input  logic              we,
   input  logic [ADDR_W-1:0] waddr,
   input  logic [DATA_W-1:0] wdata,
   input  logic [ADDR_W-1:0] raddr,
   output logic [DATA_W-1:0] rdata
);

   localparam int unsigned DEPTH = 2 ** ADDR_W;

   logic [DATA_W-1:0] mem [DEPTH];

   // No reset: contents are masked downstream until a full line is written
   always_ff @(posedge clk) begin
      if (we) begin
         mem[waddr] <= wdata;
      end
      rdata <= mem[raddr];
   end

endmodule

// File: rtl/vga_scandouble.sv
// Ping-pong line buffer scan doubler: captures a TV line at 14 MHz, replays it twice at 28 MHz.
module vga_scandouble #(
   parameter int unsigned PIX_W    = vga_scandouble_pkg::PIX_W,
   parameter int unsigned LINE_PIX = vga_scandouble_pkg::LINE_PIX
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             hsync_start,
   input  logic             wr_stb,
   input  logic [PIX_W-1:0] wr_pix,
   output logic [PIX_W-1:0] rd_pix,
   output logic             rd_valid,
   output logic             rd_half,
   output logic             wr_ovf
);

   import vga_scandouble_pkg::*;

   localparam int unsigned IDX_W  = cnt_width(LINE_PIX);
   localparam int unsigned ADDR_W = IDX_W + 1;
   localparam logic [IDX_W-1:0] CNT_FULL = IDX_W'(LINE_PIX);
   localparam logic [IDX_W-1:0] CNT_LAST = IDX_W'(LINE_PIX - 1);

   logic             wr_bank, wr_bank_nxt;
   logic [IDX_W-1:0] wr_cnt, wr_cnt_nxt;
   logic [IDX_W-1:0] wr_idx;
   logic             wr_en;
   logic             line_ok, line_ok_nxt;
   logic             ovf_nxt;
   logic [IDX_W-1:0] rd_cnt, rd_cnt_nxt;
   logic             half, half_nxt;
   logic [PIX_W-1:0] ram_q;
   rd_meta_t         meta_q;

   // Write side: bank swap and line-completeness sampled on hsync_start
   always_comb begin
      wr_bank_nxt = wr_bank;
      wr_cnt_nxt  = wr_cnt;
      wr_idx      = wr_cnt;
      line_ok_nxt = line_ok;
      wr_en       = 1'b0;
      ovf_nxt     = 1'b0;
      if (hsync_start) begin
         wr_bank_nxt = ~wr_bank;
         line_ok_nxt = (wr_cnt == CNT_FULL);
         wr_cnt_nxt  = '0;
         wr_idx      = '0;
      end
      if (wr_stb) begin
         if (hsync_start || (wr_cnt != CNT_FULL)) begin
            wr_en      = ~rst;
            wr_cnt_nxt = wr_idx + IDX_W'(1);
         end else begin
            ovf_nxt = 1'b1;
         end
      end
   end

   // Read side: free-running pass counter, restarted by hsync_start
   always_comb begin
      rd_cnt_nxt = rd_cnt + IDX_W'(1);
      half_nxt   = half;
      if (hsync_start) begin
         rd_cnt_nxt = '0;
         half_nxt   = 1'b0;
      end else if (rd_cnt == CNT_LAST) begin
         rd_cnt_nxt = '0;
         half_nxt   = ~half;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         wr_bank <= 1'b0;
         wr_cnt  <= '0;
         line_ok <= 1'b0;
         rd_cnt  <= '0;
         half    <= 1'b0;
      end else begin
         wr_bank <= wr_bank_nxt;
         wr_cnt  <= wr_cnt_nxt;
         line_ok <= line_ok_nxt;
         rd_cnt  <= rd_cnt_nxt;
         half    <= half_nxt;
      end
   end

   // Addresses use next-state values so the RAM register lines up with rd_cnt
   vga_linebuf_ram #(
      .DATA_W (PIX_W),
      .ADDR_W (ADDR_W)
   ) u_ram (
      .clk   (clk),
      .we    (wr_en),
      .waddr ({wr_bank_nxt, wr_idx}),
      .wdata (wr_pix),
      .raddr ({~wr_bank_nxt, rd_cnt_nxt}),
      .rdata (ram_q)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         rd_pix <= '0;
         meta_q <= '0;
         wr_ovf <= 1'b0;
      end else begin
         rd_pix       <= line_ok ? ram_q : '0;
         meta_q.valid <= line_ok;
         meta_q.half  <= half;
         wr_ovf       <= ovf_nxt;
      end
   end

   assign rd_valid = meta_q.valid;
   assign rd_half  = meta_q.half;

endmodule

// File: tb/tb_vga_scandouble.sv
// Randomized line-level bench for vga_scandouble against a line-snapshot reference model.
module tb_vga_scandouble;

   import vga_scandouble_pkg::*;

   localparam int LP  = int'(LINE_PIX);
   localparam int PER = int'(VGA_PERIOD);
   localparam int LAT = int'(RD_LATENCY);

   logic             clk = 1'b0;
   logic             rst;
   logic             hsync_start;
   logic             wr_stb;
   logic [PIX_W-1:0] wr_pix;
   logic [PIX_W-1:0] rd_pix;
   logic             rd_valid;
   logic             rd_half;
   logic             wr_ovf;

   int checks = 0;
   int errors = 0;
   int cyc = 0;
   int ovf_seen = 0;

   // Model: write line being captured plus the two most recent line-closing events
   logic [PIX_W-1:0] wline [LP];
   int               wcnt = 0;
   int               ev_t [2];
   bit               ev_ok [2];
   logic [PIX_W-1:0] ev_line [2][LP];

   always #5 clk = ~clk;

   vga_scandouble #(
      .PIX_W    (PIX_W),
      .LINE_PIX (LINE_PIX)
   ) dut (
      .clk         (clk),
      .rst         (rst),
      .hsync_start (hsync_start),
      .wr_stb      (wr_stb),
      .wr_pix      (wr_pix),
      .rd_pix      (rd_pix),
      .rd_valid    (rd_valid),
      .rd_half     (rd_half),
      .wr_ovf      (wr_ovf)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp)
      else begin
         errors++;
         $error("FAIL %s cycle %0d observed %0h expected %0h", tag, cyc, obs, exp);
      end
   endtask

   task automatic push_event(input int t, input bit ok);
      ev_t[0]    = ev_t[1];
      ev_ok[0]   = ev_ok[1];
      ev_line[0] = ev_line[1];
      ev_t[1]    = t;
      ev_ok[1]   = ok;
      ev_line[1] = wline;
   endtask

   // One clock: apply inputs, advance model, check outputs of the following cycle
   task automatic tick(input bit r, input bit hs, input bit stb, input logic [PIX_W-1:0] pix);
      bit               exp_ovf, exp_valid, exp_half;
      logic [PIX_W-1:0] exp_pix;
      int               e, j, k;
      rst         = r;
      hsync_start = hs;
      wr_stb      = stb;
      wr_pix      = pix;
      @(posedge clk);
      exp_ovf = 1'b0;
      if (r) begin
         push_event(cyc, 1'b0);
         wcnt = 0;
      end else begin
         exp_ovf = stb && !hs && (wcnt == LP);
         if (hs) begin
            push_event(cyc, wcnt == LP);
            wcnt = 0;
         end
         if (stb && wcnt < LP) begin
            wline[wcnt] = pix;
            wcnt++;
         end
      end
      if (r) begin
         exp_pix   = '0;
         exp_valid = 1'b0;
         exp_half  = 1'b0;
      end else begin
         e         = (ev_t[1] <= cyc + 1 - LAT) ? 1 : 0;
         j         = cyc + 1 - ev_t[e] - LAT;
         k         = j % LP;
         exp_half  = ((j / LP) % 2) == 1;
         exp_valid = ev_ok[e];
         exp_pix   = exp_valid ? ev_line[e][k] : '0;
      end
      #1;
      chk("rd_pix", 32'(rd_pix), 32'(exp_pix));
      chk("rd_valid", 32'(rd_valid), 32'(exp_valid));
      chk("rd_half", 32'(rd_half), 32'(exp_half));
      chk("wr_ovf", 32'(wr_ovf), 32'(exp_ovf));
      if (wr_ovf) ovf_seen++;
      cyc++;
   endtask

   // One TV line: hsync at offset 0, strobes every other clock (odd offsets, or even when coincident)
   task automatic tv_line(input int len, input int nstb, input bit rnd, input bit coincide,
                          input int rst_at, input int exp_first);
      int               s;
      bit               stb;
      logic [PIX_W-1:0] p;
      s = 0;
      for (int i = 0; i < len; i++) begin
         stb = (s < nstb) && ((i % 2) == (coincide ? 0 : 1));
         if (coincide && s == 0) p = PIX_W'(42);
         else if (rnd)          p = PIX_W'($urandom);
         else                   p = PIX_W'(s % 64);
         tick(i == rst_at, i == 0, stb, stb ? p : PIX_W'($urandom));
         if (stb) s++;
         if (i == LAT - 1 && exp_first >= 0) chk("first_pix", 32'(rd_pix), 32'(exp_first));
      end
   endtask

   initial begin
      int len, n;
      ev_t[0] = -10000;
      ev_t[1] = -10000;
      ev_ok   = '{1'b0, 1'b0};
      tick(1'b1, 1'b0, 1'b0, '0);
      tick(1'b1, 1'b0, 1'b0, '0);
      for (int i = 0; i < 5; i++) tick(1'b0, 1'b0, 1'b0, '0);

      tv_line(PER, LP, 1'b0, 1'b0, -1, 0);
      tv_line(PER, LP, 1'b0, 1'b0, -1, 0);
      tv_line(PER, 300, 1'b1, 1'b0, -1, 0);
      tv_line(PER, LP, 1'b1, 1'b0, -1, 0);
      ovf_seen = 0;
      tv_line(1000, LP + 12, 1'b1, 1'b0, -1, -1);
      chk("ovf_count", 32'(ovf_seen), 32'd12);
      tv_line(PER, LP, 1'b1, 1'b1, -1, -1);
      tv_line(PER, LP, 1'b1, 1'b0, -1, 42);
      tv_line(PER, LP, 1'b1, 1'b0, 600, -1);
      tv_line(PER, LP, 1'b1, 1'b0, -1, 0);
      tv_line(PER, LP, 1'b1, 1'b0, -1, -1);
      tv_line(PER, LP, 1'b1, 1'b0, -1, -1);
      for (int i = 0; i < 4; i++) begin
         len = int'($urandom_range(700, 1000));
         n   = int'($urandom_range(250, 470));
         tv_line(len, n, 1'b1, ($urandom_range(0, 1) == 1), -1, -1);
      end
      for (int i = 0; i < 4; i++) tick(1'b0, 1'b0, 1'b0, '0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
